// File: rtl/qam_tx_sequencer.sv
`default_nettype none
// qam_tx_sequencer -- PREAMBLE/DATA/GUARD frame sequencer driving carrier and symbol strobes.
// Revision 1.0
module qam_tx_sequencer #(
  parameter int CARRIER_DIV     = 4,
  parameter int SAMPLES_PER_SYM = 16,
  parameter int PREAMBLE_SYMS   = 8,
  parameter int GUARD_SYMS      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [7:0] frame_len_i,
  input  logic       sym_valid_i,
  input  logic [3:0] sym_data_i,
  output logic       sym_ready_o,
  output logic       carrier_en_o,
  output logic       sym_load_o,
  output logic [1:0] sym_i_o,
  output logic [1:0] sym_q_o,
  output logic       tx_on_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       underrun_o
);

  localparam int SW = $clog2(CARRIER_DIV);
  localparam int PW = $clog2(SAMPLES_PER_SYM);
  localparam logic [SW-1:0] SAMP_LAST  = SW'(CARRIER_DIV - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(SAMPLES_PER_SYM - 1);
  localparam logic [7:0]    PRE_LAST   = 8'(PREAMBLE_SYMS - 1);
  localparam logic [7:0]    GRD_LAST   = 8'(GUARD_SYMS - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_GUARD    = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   samp_q, samp_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      flen_q, flen_d;
  logic [1:0]      si_q, si_d;
  logic [1:0]      sq_q, sq_d;
  logic            load_q, load_d;
  logic            done_q, done_d;
  logic            ur_q, ur_d;

  logic            busy;
  logic            carrier_en;
  logic            sym_tick;
  logic            xfer_slot;
  logic [1:0]      in_i, in_q;

  assign busy       = (state_q != ST_IDLE);
  assign carrier_en = busy && (samp_q == SAMP_LAST);
  assign sym_tick   = carrier_en && (phase_q == PHASE_LAST);
  // Nine-bit compare keeps cnt < frame_len-1 safe when frame_len is 1.
  assign xfer_slot  = ((state_q == ST_PREAMBLE) && (cnt_q == PRE_LAST)) ||
                      ((state_q == ST_DATA) && (({1'b0, cnt_q} + 9'd1) < {1'b0, flen_q}));
  assign in_i       = sym_valid_i ? sym_data_i[3:2] : 2'b00;
  assign in_q       = sym_valid_i ? sym_data_i[1:0] : 2'b00;

  assign sym_ready_o  = sym_tick && xfer_slot && !abort_i;
  assign carrier_en_o = carrier_en;
  assign sym_load_o   = load_q;
  assign sym_i_o      = si_q;
  assign sym_q_o      = sq_q;
  assign tx_on_o      = (state_q == ST_PREAMBLE) || (state_q == ST_DATA);
  assign busy_o       = busy;
  assign done_o       = done_q;
  assign underrun_o   = ur_q;

  always_comb begin
    state_d = state_q;
    samp_d  = samp_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    flen_d  = flen_q;
    si_d    = si_q;
    sq_d    = sq_q;
    load_d  = 1'b0;
    done_d  = 1'b0;
    ur_d    = ur_q;

    if (busy) begin
      samp_d = carrier_en ? '0 : samp_q + SW'(1);
      if (carrier_en) begin
        phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        samp_d  = '0;
        phase_d = '0;
        cnt_d   = '0;
        if (start_i && (frame_len_i != 8'd0)) begin
          state_d = ST_PREAMBLE;
          flen_d  = frame_len_i;
          si_d    = 2'b11;
          sq_d    = 2'b11;
          load_d  = 1'b1;
          ur_d    = 1'b0;
        end
      end
      ST_PREAMBLE, ST_DATA: begin
        if (abort_i) begin
          state_d = ST_GUARD;
          samp_d  = '0;
          phase_d = '0;
          cnt_d   = '0;
          si_d    = 2'b00;
          sq_d    = 2'b00;
          load_d  = 1'b1;
        end else if (sym_tick) begin
          load_d = 1'b1;
          cnt_d  = cnt_q + 8'd1;
          if ((state_q == ST_PREAMBLE) && (cnt_q != PRE_LAST)) begin
            // Next preamble symbol index is cnt+1: even -> 11, odd -> 00.
            si_d = {2{cnt_q[0]}};
            sq_d = {2{cnt_q[0]}};
          end else if (xfer_slot) begin
            si_d = in_i;
            sq_d = in_q;
            if (!sym_valid_i) begin
              ur_d = 1'b1;
            end
            if (state_q == ST_PREAMBLE) begin
              state_d = ST_DATA;
              cnt_d   = '0;
            end
          end else begin
            state_d = ST_GUARD;
            cnt_d   = '0;
            si_d    = 2'b00;
            sq_d    = 2'b00;
          end
        end
      end
      ST_GUARD: begin
        if (sym_tick) begin
          load_d = 1'b1;
          si_d   = 2'b00;
          sq_d   = 2'b00;
          if (cnt_q == GRD_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      samp_q  <= '0;
      phase_q <= '0;
      cnt_q   <= '0;
      flen_q  <= '0;
      si_q    <= '0;
      sq_q    <= '0;
      load_q  <= 1'b0;
      done_q  <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      flen_q  <= flen_d;
      si_q    <= si_d;
      sq_q    <= sq_d;
      load_q  <= load_d;
      done_q  <= done_d;
      ur_q    <= ur_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qam_tx_sequencer.sv
`default_nettype none
// tb_qam_tx_sequencer -- randomized frame scenarios against a timeline model of the sequencer.
// Revision 1.0
module tb_qam_tx_sequencer;

  localparam int CD  = 4;
  localparam int SPS = 16;
  localparam int PRE = 8;
  localparam int GRD = 4;
  localparam int P   = CD * SPS;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] frame_len;
  logic       sym_valid;
  logic [3:0] sym_data;
  logic       sym_ready;
  logic       carrier_en;
  logic       sym_load;
  logic [1:0] sym_i;
  logic [1:0] sym_q;
  logic       tx_on;
  logic       busy;
  logic       done;
  logic       underrun;

  int checks   = 0;
  int failures = 0;

  logic       vld [0:4095];
  logic [3:0] dat [0:4095];

  always #5 clk = ~clk;

  qam_tx_sequencer #(
    .CARRIER_DIV     (CD),
    .SAMPLES_PER_SYM (SPS),
    .PREAMBLE_SYMS   (PRE),
    .GUARD_SYMS      (GRD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .abort_i      (abort),
    .frame_len_i  (frame_len),
    .sym_valid_i  (sym_valid),
    .sym_data_i   (sym_data),
    .sym_ready_o  (sym_ready),
    .carrier_en_o (carrier_en),
    .sym_load_o   (sym_load),
    .sym_i_o      (sym_i),
    .sym_q_o      (sym_q),
    .tx_on_o      (tx_on),
    .busy_o       (busy),
    .done_o       (done),
    .underrun_o   (underrun)
  );

  // Bit order: busy tx_on carrier_en sym_ready sym_load done underrun sym_i[1:0] sym_q[1:0]
  function automatic logic [10:0] obs();
    return {busy, tx_on, carrier_en, sym_ready, sym_load, done, underrun, sym_i, sym_q};
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; frame_len = 8'd0;
    sym_valid = 1'b0; sym_data = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (obs() !== 11'd0) begin
      failures++;
      $display("FAIL reset outputs got=%b exp=%b", obs(), 11'd0);
    end
    @(posedge clk);
  endtask

  task automatic test_zero_len();
    #1 start = 1'b1; frame_len = 8'd0;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 start = 1'b0;
      #1;
      checks++;
      if (obs() !== 11'd0) begin
        failures++;
        $display("FAIL zero_len cycle=%0d got=%b exp=%b", i, obs(), 11'd0);
      end
      @(posedge clk);
    end
  endtask

  // mode 0: always valid, 1: random valid, 2: invalid only at the second data slot
  task automatic test_frame(input string name, input int L, input int mode,
                            input int abort_t, input int rst_t, input int bstart_t);
    int act_end, end_busy, last_t, s, tj;
    logic eb, et, ec, er, el, ed, eu;
    logic [1:0] ei, eq;
    logic [10:0] exp_v;

    act_end  = (abort_t != 0) ? abort_t : (PRE + L) * P;
    end_busy = act_end + GRD * P;
    last_t   = (rst_t != 0) ? rst_t + 1 : end_busy + 2;

    for (int t = 0; t < 4096; t++) begin
      dat[t] = 4'($urandom);
      case (mode)
        0:       vld[t] = 1'b1;
        1:       vld[t] = ($urandom_range(0, 3) != 0);
        default: vld[t] = (t != (PRE + 1) * P);
      endcase
    end

    #1 start = 1'b1; frame_len = 8'(L); abort = 1'b0; sym_valid = 1'b0;
    @(posedge clk);

    for (int t = 1; t <= last_t; t++) begin
      #1;
      start     = (t == bstart_t);
      frame_len = (t == bstart_t) ? 8'($urandom_range(1, 255)) : 8'(L);
      abort     = (t == abort_t);
      rst       = (t == rst_t);
      sym_valid = vld[t];
      sym_data  = dat[t];
      #1;

      eb = 0; et = 0; ec = 0; er = 0; el = 0; ed = 0; eu = 0; ei = 0; eq = 0;
      if (rst_t != 0 && t > rst_t) begin
        exp_v = 11'd0;
      end else begin
        if (t <= act_end) begin
          eb = 1; et = 1;
          ec = (t % CD == 0);
          el = ((t - 1) % P == 0);
          er = (t % P == 0) && (t / P >= PRE) && (t / P < PRE + L) && (t != abort_t);
          s  = (t - 1) / P;
          if (s < PRE) begin
            ei = (s % 2 == 0) ? 2'b11 : 2'b00;
            eq = ei;
          end else if (vld[s * P]) begin
            ei = dat[s * P][3:2];
            eq = dat[s * P][1:0];
          end
        end else if (t <= end_busy) begin
          eb = 1;
          ec = ((t - act_end) % CD == 0);
          el = ((t - act_end - 1) % P == 0);
        end else if (t == end_busy + 1) begin
          el = 1; ed = 1;
        end
        for (int j = 0; j < L; j++) begin
          tj = (PRE + j) * P;
          if (tj < t && tj <= act_end && tj != abort_t && !vld[tj]) eu = 1;
        end
        exp_v = {eb, et, ec, er, el, ed, eu, ei, eq};
      end

      checks++;
      if (obs() !== exp_v) begin
        failures++;
        if (failures <= 20)
          $display("FAIL %s t=%0d got=%b exp=%b", name, t, obs(), exp_v);
      end
      @(posedge clk);
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
  endtask

  task automatic test_random_frames();
    int L, a;
    for (int k = 0; k < 5; k++) begin
      L = $urandom_range(1, 6);
      a = ($urandom_range(0, 1) == 1) ? $urandom_range(1, (PRE + L) * P) : 0;
      test_frame("random", L, 1, a, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_zero_len();
    test_frame("basic_len3", 3, 0, 0, 0, 0);
    test_frame("underrun", 3, 2, 0, 0, 0);
    test_frame("abort_300", 3, 0, 300, 0, 0);
    test_frame("busy_start", 3, 0, 0, 0, 100);
    test_frame("rst_mid", 3, 0, 0, 600, 0);
    test_frame("after_rst", 3, 0, 0, 0, 0);
    test_frame("len1", 1, 1, 0, 0, 0);
    test_frame("abort_at_tick", 2, 0, (PRE + 1) * P, 0, 0);
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
